avmm_cmd_master: RTL and testbench

//  Avalon-MM master (initiator) converting a one-at-a-time command interface into

---
 rtl/avmm_cmd_master.sv | 144 ++++++++++++++
 tb/tb_avmm_cmd_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_cmd_master.sv
// Avalon-MM single-word master: one command in flight at a time, with waitrequest stalls,
// optional readdatavalid reads and a per-transfer timeout that aborts with rsp_timeout.
module avmm_cmd_master #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int USE_RDV        = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT_RDV, S_RESP} state_t;

  state_t              r_state;
  logic                r_wr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_rsp_timeout;
  logic [DATA_W-1:0]   r_rsp_readdata;
  logic [ADDR_W-1:0]   r_avm_address;
  logic                r_avm_read;
  logic                r_avm_write;
  logic [DATA_W-1:0]   r_avm_writedata;

  logic                w_tmo;
  logic [CNT_W-1:0]    w_cnt_inc;

  // Saturating increment: a read can finish its bus phase on the final count and
  // still needs the timeout to fire from WAIT_RDV on the next edge.
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt >= TMO_LAST);
  assign w_cnt_inc = w_tmo ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_wr            <= 1'b0;
      r_cnt           <= '0;
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_rsp_readdata  <= '0;
      r_avm_address   <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_wr            <= cmd_write;
            r_avm_address   <= cmd_address;
            r_avm_writedata <= cmd_writedata;
            r_avm_write     <= cmd_write;
            r_avm_read      <= !cmd_write;
            r_cmd_ready     <= 1'b0;
            r_cnt           <= '0;
            r_state         <= S_BUS;
          end
        end
        S_BUS: begin
          if (!avm_waitrequest) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            if (r_wr) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (USE_RDV == 0 || avm_readdatavalid) begin
              r_rsp_readdata <= avm_readdata;
              r_rsp_valid    <= 1'b1;
              r_state        <= S_RESP;
            end else begin
              r_cnt   <= w_cnt_inc;
              r_state <= S_WAIT_RDV;
            end
          end else if (w_tmo) begin
            r_avm_read     <= 1'b0;
            r_avm_write    <= 1'b0;
            r_rsp_readdata <= '0;
            r_rsp_timeout  <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_RDV: begin
          if (avm_readdatavalid) begin
            r_rsp_readdata <= avm_readdata;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else if (w_tmo) begin
            r_rsp_readdata <= '0;
            r_rsp_timeout  <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_timeout   = r_rsp_timeout;
  assign rsp_readdata  = r_rsp_readdata;
  assign avm_address   = r_avm_address;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_writedata;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: two instances (plain read capture and readdatavalid reads) share one
// command stream; each has its own slave stimulus, checked cycle by cycle against a transaction model.
module tb_avmm_cmd_master;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_writedata;

  logic          cmd_ready         [2];
  logic          rsp_valid         [2];
  logic          rsp_timeout       [2];
  logic [DW-1:0] rsp_readdata      [2];
  logic [AW-1:0] avm_address       [2];
  logic          avm_read          [2];
  logic          avm_write         [2];
  logic [DW-1:0] avm_writedata     [2];
  logic [DW-1:0] avm_readdata      [2];
  logic          avm_waitrequest   [2];
  logic          avm_readdatavalid [2];

  avmm_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .USE_RDV(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid[0]), .rsp_readdata(rsp_readdata[0]), .rsp_timeout(rsp_timeout[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
    .avm_waitrequest(avm_waitrequest[0]), .avm_readdatavalid(avm_readdatavalid[0])
  );

  avmm_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .USE_RDV(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid[1]), .rsp_readdata(rsp_readdata[1]), .rsp_timeout(rsp_timeout[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
    .avm_waitrequest(avm_waitrequest[1]), .avm_readdatavalid(avm_readdatavalid[1])
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mem     [8];
  logic [DW-1:0] last_rd [2];

  task automatic chk(input string tag, input int k, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // One command through both masters. stl[k]: waitrequest cycles before release; rdel: cycles
  // from bus completion to readdatavalid (dut1 reads); stuck: waitrequest never drops;
  // nordv: dut1 never gets readdatavalid; hold: cmd_valid kept high with junk while busy.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int st0, input int st1, input int rdel,
                        input logic stuck, input logic nordv, input logic hold);
    int S [2];
    int R [2];
    int st [2];
    logic tmo [2];
    logic [DW-1:0] newrd [2];
    int rmax, rmin;
    st[0] = st0;
    st[1] = st1;
    for (int k = 0; k < 2; k++) begin
      S[k] = stuck ? TMO : st[k] + 1;
      if (stuck || (k == 1 && !wr && nordv)) begin
        R[k] = TMO + 1;
        tmo[k] = 1'b1;
      end else begin
        R[k] = (k == 1 && !wr) ? S[k] + rdel + 1 : S[k] + 1;
        tmo[k] = 1'b0;
      end
      newrd[k] = tmo[k] ? '0 : (!wr ? mem[addr[4:2]] : last_rd[k]);
    end
    rmax = (R[0] > R[1]) ? R[0] : R[1];
    rmin = (R[0] < R[1]) ? R[0] : R[1];

    for (int k = 0; k < 2; k++) chk1("ready_before_cmd", k, cmd_ready[k], 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_address = addr;
    cmd_writedata = data;
    for (int k = 0; k < 2; k++) begin
      avm_waitrequest[k] = 1'b1;
      avm_readdata[k] = $urandom;
      avm_readdatavalid[k] = 1'($urandom);
    end
    @(posedge clk);
    for (int n = 1; n <= rmax + 1; n++) begin
      @(negedge clk);
      if (hold && n <= rmin) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_address = AW'($urandom);
        cmd_writedata = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        chk1("avm_write", k, avm_write[k], (n <= S[k]) && wr);
        chk1("avm_read", k, avm_read[k], (n <= S[k]) && !wr);
        if (n <= S[k]) chk("avm_address", k, {27'b0, avm_address[k]}, {27'b0, addr});
        if (n <= S[k] && wr) chk("avm_writedata", k, avm_writedata[k], data);
        chk1("rsp_valid", k, rsp_valid[k], n == R[k]);
        if (n == R[k]) chk1("rsp_timeout", k, rsp_timeout[k], tmo[k]);
        chk("rsp_readdata", k, rsp_readdata[k], (n >= R[k]) ? newrd[k] : last_rd[k]);
        chk1("cmd_ready", k, cmd_ready[k], n > R[k]);

        avm_waitrequest[k] = stuck || (n <= st[k]);
        if (!wr && !stuck && ((k == 0 && n == S[0]) || (k == 1 && !nordv && n == S[1] + rdel)))
          avm_readdata[k] = mem[addr[4:2]];
        else
          avm_readdata[k] = $urandom;
        if (k == 1 && !wr)
          avm_readdatavalid[k] = (!stuck && !nordv && n == S[1] + rdel) ? 1'b1 :
                                 ((n < S[1] || n >= R[1]) ? 1'($urandom) : 1'b0);
        else
          avm_readdatavalid[k] = 1'($urandom);
      end
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) last_rd[k] = newrd[k];
    if (wr && !stuck) mem[addr[4:2]] = data;
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = '0;
    cmd_writedata = '0;
    for (int k = 0; k < 2; k++) begin
      avm_readdata[k] = '0;
      avm_waitrequest[k] = 1'b0;
      avm_readdatavalid[k] = 1'b0;
      last_rd[k] = '0;
    end
    for (int i = 0; i < 8; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk1("rst_cmd_ready", k, cmd_ready[k], 1'b1);
      chk1("rst_rsp_valid", k, rsp_valid[k], 1'b0);
      chk1("rst_rsp_timeout", k, rsp_timeout[k], 1'b0);
      chk("rst_rsp_readdata", k, rsp_readdata[k], '0);
      chk1("rst_avm_read", k, avm_read[k], 1'b0);
      chk1("rst_avm_write", k, avm_write[k], 1'b0);
      chk("rst_avm_address", k, {27'b0, avm_address[k]}, '0);
      chk("rst_avm_writedata", k, avm_writedata[k], '0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b1, 5'd4, 32'h0000_00FF, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b1, 5'd8, 32'h0000_00A5, 3, 3, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b1, 5'd0, 32'h0000_005A, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 5'd0, 32'h0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 5'd12, 32'h0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    do_cmd(1'b0, 5'd8, 32'h0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 5'd4, 32'h0, 1, 2, 0, 1'b0, 1'b1, 1'b0);
    do_cmd(1'b1, 5'd4, 32'hFFFF_FFFF, 1, 2, 0, 1'b0, 1'b0, 1'b1);
    do_cmd(1'b0, 5'd4, 32'h0, 0, 1, 1, 1'b0, 1'b0, 1'b1);
    do_cmd(1'b0, 5'd8, 32'h0, 2, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_cmd(1'($urandom), {3'($urandom), 2'b00}, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'b0, 1'b0, 1'($urandom));
    end

    // Reset in the middle of a stalled transfer.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_address = 5'd4;
    for (int k = 0; k < 2; k++) begin
      avm_waitrequest[k] = 1'b1;
      avm_readdatavalid[k] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) chk1("stall_read_high", k, avm_read[k], 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1("async_rst_read", k, avm_read[k], 1'b0);
      chk1("async_rst_write", k, avm_write[k], 1'b0);
      chk1("async_rst_rsp_valid", k, rsp_valid[k], 1'b0);
      chk1("async_rst_cmd_ready", k, cmd_ready[k], 1'b1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      avm_waitrequest[k] = 1'b0;
      last_rd[k] = '0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk1("post_rst_rsp_valid", k, rsp_valid[k], 1'b0);
        chk1("post_rst_cmd_ready", k, cmd_ready[k], 1'b1);
        chk1("post_rst_read", k, avm_read[k], 1'b0);
      end
    end
    do_cmd(1'b0, 5'd4, 32'h0, 0, 0, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
